// File: rtl/button_event_encoder.sv
// Debounced active-low push-buttons turned into a queue of press events.
// Sync -> per-button debounce -> pending bits -> priority arbiter -> FIFO.
module button_event_encoder #(
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] pressed_level,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [2:0]         evt_id,
  output logic               overflow,
  input  logic               clear_overflow
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);

  logic [NUM_BTN-1:0]         r_sync1;
  logic [NUM_BTN-1:0]         r_sync2;
  logic [NUM_BTN-1:0]         r_stable;
  logic [NUM_BTN-1:0]         r_level;
  logic [NUM_BTN-1:0]         r_pending;
  logic [NUM_BTN-1:0][CW-1:0] r_cnt;
  logic [2:0]                 r_mem [FIFO_DEPTH];
  logic [AW-1:0]              r_wr_ptr;
  logic [AW-1:0]              r_rd_ptr;
  logic [AW:0]                r_count;
  logic                       r_evt_valid;
  logic [2:0]                 r_evt_id;
  logic                       r_overflow;

  logic [NUM_BTN-1:0] w_press;
  logic [NUM_BTN-1:0] w_done;
  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] w_loss;
  logic [NUM_BTN-1:0] w_sel;
  logic [NUM_BTN-1:0] w_pending_next;
  logic [2:0]         w_idx;
  logic               w_full;
  logic               w_wr;
  logic               w_pop;
  logic [AW-1:0]      w_head_ptr;
  logic [AW:0]        w_left;

  always_comb begin
    w_press = ~r_sync2;
    for (int i = 0; i < NUM_BTN; i++) begin
      w_done[i] = (w_press[i] != r_stable[i]) && (r_cnt[i] == CMAX);
    end
    w_rise = w_done & ~r_stable;
    w_loss = w_rise & r_pending;
    w_idx  = '0;
    w_sel  = '0;
    // Descending scan so the lowest set index is the last one kept.
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_idx    = 3'(i);
        w_sel    = '0;
        w_sel[i] = 1'b1;
      end
    end
    w_full = (r_count == FULL);
    w_wr   = (|r_pending) && !w_full;
    w_pop  = r_evt_valid && evt_ready;
    w_pending_next = (r_pending & ~(w_wr ? w_sel : '0))
                   | (w_rise & ~r_pending);
    w_head_ptr = r_rd_ptr + AW'(w_pop);
    // Head register sees the FIFO before this cycle's write.
    w_left = r_count - (AW+1)'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1     <= '1;
      r_sync2     <= '1;
      r_stable    <= '0;
      r_level     <= '0;
      r_pending   <= '0;
      r_cnt       <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_evt_valid <= 1'b0;
      r_evt_id    <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (w_press[i] == r_stable[i] || w_done[i]) r_cnt[i] <= '0;
        else r_cnt[i] <= r_cnt[i] + CW'(1);
      end
      r_stable  <= r_stable ^ w_done;
      r_level   <= r_stable;
      r_pending <= w_pending_next;
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
      r_evt_valid <= (w_left != '0);
      r_evt_id    <= (w_left != '0) ? r_mem[w_head_ptr] : 3'd0;
      if (|w_loss) r_overflow <= 1'b1;
      else if (clear_overflow) r_overflow <= 1'b0;
    end
  end

  assign pressed_level = r_level;
  assign evt_valid     = r_evt_valid;
  assign evt_id        = r_evt_id;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_button_event_encoder.sv
// Directed bench for button_event_encoder with a short debounce window.
module tb_button_event_encoder;
  localparam int NB = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_n;
  logic [NB-1:0] pressed_level;
  logic          evt_valid;
  logic          evt_ready;
  logic [2:0]    evt_id;
  logic          overflow;
  logic          clear_overflow;

  int errors = 0;
  int checks = 0;
  int got[16];
  int n_got;

  always #5 clk = ~clk;

  button_event_encoder #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n),
    .pressed_level(pressed_level), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_id(evt_id),
    .overflow(overflow), .clear_overflow(clear_overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic tap(input int b);
    btn_n[b] = 1'b0;
    idle(8);
    btn_n[b] = 1'b1;
    idle(8);
  endtask

  task automatic collect(input int budget);
    n_got = 0;
    evt_ready = 1'b1;
    for (int k = 0; k < budget; k++) begin
      if (evt_valid && n_got < 16) begin
        got[n_got] = int'(evt_id);
        n_got++;
      end
      tick();
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn_n = '1;
    evt_ready = 1'b0;
    clear_overflow = 1'b0;
    idle(3);
    checks++;
    if (pressed_level !== 5'b0) begin
      errors++;
      $display("FAIL rst_level got=%b exp=0", pressed_level);
    end
    checks++;
    if (evt_valid !== 1'b0 || evt_id !== 3'd0) begin
      errors++;
      $display("FAIL rst_evt got=%b/%0d exp=0/0", evt_valid, evt_id);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_ovf got=%b exp=0", overflow);
    end
    reset = 1'b0;
    idle(2);
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_valid got=%b exp=0", evt_valid);
    end
  endtask

  task automatic test_latency();
    evt_ready = 1'b1;
    btn_n[2] = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      tick();
      checks++;
      if (pressed_level !== ((k >= 6) ? 5'b00100 : 5'b0)) begin
        errors++;
        $display("FAIL lat_level k=%0d got=%b", k, pressed_level);
      end
      checks++;
      if (evt_valid !== (k == 7)) begin
        errors++;
        $display("FAIL lat_valid k=%0d got=%b exp=%b",
                 k, evt_valid, (k == 7));
      end
      if (k == 7) begin
        checks++;
        if (evt_id !== 3'd2) begin
          errors++;
          $display("FAIL lat_id got=%0d exp=2", evt_id);
        end
      end
    end
    btn_n[2] = 1'b1;
    n_got = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (evt_valid) n_got++;
    end
    checks++;
    if (n_got != 0 || pressed_level !== 5'b0) begin
      errors++;
      $display("FAIL release got=%0d/%b exp=0/0", n_got, pressed_level);
    end
  endtask

  task automatic test_glitch();
    btn_n[1] = 1'b0;
    idle(3);
    btn_n[1] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++;
      if (pressed_level !== 5'b0 || evt_valid !== 1'b0) begin
        errors++;
        $display("FAIL glitch k=%0d got=%b/%b exp=0/0",
                 k, pressed_level, evt_valid);
      end
    end
  endtask

  task automatic test_simultaneous();
    evt_ready = 1'b1;
    btn_n[0] = 1'b0;
    btn_n[3] = 1'b0;
    for (int k = 0; k <= 11; k++) begin
      tick();
      checks++;
      if (evt_valid !== (k == 7 || k == 8)) begin
        errors++;
        $display("FAIL simul_valid k=%0d got=%b", k, evt_valid);
      end
      if (k == 7 || k == 8) begin
        checks++;
        if (evt_id !== ((k == 7) ? 3'd0 : 3'd3)) begin
          errors++;
          $display("FAIL simul_id k=%0d got=%0d", k, evt_id);
        end
      end
    end
    btn_n = '1;
    idle(10);
    evt_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int exp_ids[5];
    exp_ids = '{0, 1, 2, 3, 4};
    evt_ready = 1'b0;
    for (int b = 0; b < 5; b++) tap(b);
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 3'd0) begin
      errors++;
      $display("FAIL bp_head got=%b/%0d exp=1/0", evt_valid, evt_id);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL bp_ovf got=%b exp=0", overflow);
    end
    collect(20);
    checks++;
    if (n_got != 5) begin
      errors++;
      $display("FAIL bp_count got=%0d exp=5", n_got);
    end
    for (int i = 0; i < 5 && i < n_got; i++) begin
      checks++;
      if (got[i] != exp_ids[i]) begin
        errors++;
        $display("FAIL bp_id[%0d] got=%0d exp=%0d", i, got[i], exp_ids[i]);
      end
    end
  endtask

  task automatic test_overflow();
    int exp_ids[5];
    exp_ids = '{1, 2, 3, 4, 0};
    evt_ready = 1'b0;
    for (int b = 1; b < 5; b++) tap(b);
    tap(0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_early got=%b exp=0", overflow);
    end
    btn_n[0] = 1'b0;
    idle(8);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set got=%b exp=1", overflow);
    end
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 3'd1) begin
      errors++;
      $display("FAIL ovf_hold got=%b/%0d exp=1/1", evt_valid, evt_id);
    end
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got=%b exp=0", overflow);
    end
    btn_n[0] = 1'b1;
    idle(8);
    collect(30);
    checks++;
    if (n_got != 5) begin
      errors++;
      $display("FAIL ovf_count got=%0d exp=5", n_got);
    end
    for (int i = 0; i < 5 && i < n_got; i++) begin
      checks++;
      if (got[i] != exp_ids[i]) begin
        errors++;
        $display("FAIL ovf_id[%0d] got=%0d exp=%0d", i, got[i], exp_ids[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    evt_ready = 1'b0;
    tap(1);
    tap(2);
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 3'd1) begin
      errors++;
      $display("FAIL mid_pre got=%b/%0d exp=1/1", evt_valid, evt_id);
    end
    reset = 1'b1;
    #2;
    checks++;
    if (evt_valid !== 1'b0 || evt_id !== 3'd0) begin
      errors++;
      $display("FAIL mid_async got=%b/%0d exp=0/0", evt_valid, evt_id);
    end
    idle(2);
    reset = 1'b0;
    evt_ready = 1'b1;
    n_got = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (evt_valid) n_got++;
    end
    checks++;
    if (n_got != 0) begin
      errors++;
      $display("FAIL mid_after got=%0d exp=0", n_got);
    end
  endtask

  task automatic test_held_reset();
    evt_ready = 1'b1;
    reset = 1'b1;
    btn_n[3] = 1'b0;
    idle(2);
    reset = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      tick();
      checks++;
      if (evt_valid !== (k == 7)) begin
        errors++;
        $display("FAIL held_valid k=%0d got=%b exp=%b",
                 k, evt_valid, (k == 7));
      end
      if (k == 7) begin
        checks++;
        if (evt_id !== 3'd3 || pressed_level !== 5'b01000) begin
          errors++;
          $display("FAIL held_id got=%0d/%b exp=3/01000",
                   evt_id, pressed_level);
        end
      end
    end
    btn_n[3] = 1'b1;
    idle(10);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_simultaneous();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_held_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_event_encoder.md
BUTTON_EVENT_ENCODER -- requirements
Module: button_event_encoder

Interface
REQ-001 SHALL have parameter NUM_BTN, default 5: number of active-low push-buttons.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: event FIFO entries, power of two.
REQ-004 SHALL have one clock and an asynchronous, active-high reset; all state SHALL be in the clk domain.
REQ-005 SHALL have port clk, input, 1: system clock.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port btn_n, input, NUM_BTN: raw asynchronous buttons, 0 = pressed.
REQ-008 SHALL have port pressed_level, output, NUM_BTN: debounced state, 1 = pressed.
REQ-009 SHALL have port evt_valid, output, 1: FIFO head holds a press event.
REQ-010 SHALL have port evt_ready, input, 1: consumer accepts the head event.
REQ-011 SHALL have port evt_id, output, 3: button index of the head event, 0-based.
REQ-012 SHALL have port overflow, output, 1: sticky flag, set when a press event was lost.
REQ-013 SHALL have port clear_overflow, input, 1: synchronous clear of overflow.

Function
REQ-014 SHALL pass each btn_n bit through a 2-flop synchronizer; the synchronizer output is sync[i].
REQ-015 SHALL keep a per-button debounce counter, wide enough for DEBOUNCE_CYCLES.
- Counter increments on each cycle sync[i] != stable[i].
- Counter clears on any cycle sync[i] == stable[i].
REQ-016 SHALL toggle stable[i] and clear the counter on the edge where the counter would reach DEBOUNCE_CYCLES.
REQ-017 SHALL drive pressed_level[i] = stable[i], registered.
REQ-018 Press detect: a stable[i] transition from 0 to 1 SHALL set pending[i] on that same edge; releases SHALL generate no event.
REQ-019 SHALL set overflow, drop the new press, and keep the existing pending[i] if a press is detected while pending[i] is already 1.
REQ-020 Arbiter:
- Each cycle the FIFO is not full, the lowest-index set pending bit SHALL be written to the FIFO and cleared.
- At most one write per cycle.
REQ-021 SHALL hold pending bits while the FIFO is full; they are not lost.
REQ-022 SHALL expose the FIFO head on evt_valid/evt_id, registered, with evt_valid = FIFO not empty.
REQ-023 Handshake: the head SHALL pop on a cycle with evt_valid && evt_ready.
- evt_id SHALL hold stable while evt_valid is high and evt_ready is low.
REQ-024 SHALL treat FIFO full as unwritable that cycle, even if a pop occurs simultaneously.
- Simultaneous write and pop when not full SHALL keep count unchanged.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-026 Latency: if btn_n falls and stays low, with the FIFO empty and no pending bits:
- pressed_level rises DEBOUNCE_CYCLES+2 cycles after the first edge sampling btn_n low.
- evt_valid rises one cycle later.
REQ-027 Glitches: a btn_n pulse shorter than DEBOUNCE_CYCLES cycles (after synchronization) SHALL produce no change and no event.
REQ-028 clear_overflow SHALL clear overflow; if a new loss occurs on the same cycle, set SHALL win.
REQ-029 evt_id SHALL be zero-extended from the button index; NUM_BTN SHALL be at most 8.

Reset
REQ-030 Reset SHALL, asynchronously, set:
- synchronizer flops to 1 (released);
- stable to 0;
- counters, pending, FIFO pointers and count to 0;
- pressed_level, evt_valid, evt_id and overflow to 0.
REQ-031 SHALL treat a button held through reset release as a new press, reported after the normal debounce latency.
REQ-032 Reset mid-debounce or mid-handshake SHALL discard all queued events; no event SHALL appear before a fresh debounce completes.

Verification (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4)
REQ-033 btn_n[2] held low from cycle 0, evt_ready=1 -> pressed_level[2]=1 at cycle 6; evt_valid=1 with evt_id=2 at cycle 7 for exactly 1 cycle.
REQ-034 btn_n[1] low for 3 cycles, then high -> pressed_level stays 0, evt_valid stays 0.
REQ-035 btn_n[0] and btn_n[3] fall on the same cycle, evt_ready=1 -> events id 0 then id 3 on consecutive cycles.
REQ-036 evt_ready=0; buttons 0-4 each pressed and released in sequence:
- Result: 4 events queued, pending[4] held, overflow=0.
- Then evt_ready=1: ids 0, 1, 2, 3, 4 are delivered in order.
REQ-037 evt_ready=0, FIFO full, pending[0]=1; button 0 released then pressed again -> overflow=1; clear_overflow pulse -> overflow=0.
REQ-038 Reset asserted while 2 events are queued -> evt_valid=0 immediately; with buttons released after reset, no events occur.
